// File: rtl/pointer_src_arbiter.sv
// pointer_src_arbiter
// Shares the on-screen cursor between the USB mouse path and the button-driven
// cursor path. The source that moved last takes ownership and keeps it until it
// has been quiet for HOLD_CYCLES clocks. The owner's position is clamped to the
// panel window and registered for the draw pipeline. A seed pulse lets the
// button path resync to the live cursor whenever it takes over.

module pointer_src_arbiter #(
    parameter int unsigned HOLD_CYCLES = 650000,
    parameter logic [11:0] X_MIN       = 12'd0,
    parameter logic [11:0] X_MAX       = 12'd1023,
    parameter logic [11:0] Y_MIN       = 12'd0,
    parameter logic [11:0] Y_MAX       = 12'd767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] m_xpos,
    input  logic [11:0] m_ypos,
    input  logic        m_left,
    input  logic [11:0] b_xpos,
    input  logic [11:0] b_ypos,
    input  logic        b_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        mouse_left,
    output logic        src_btn,
    output logic        seed_load,
    output logic [11:0] seed_xpos,
    output logic [11:0] seed_ypos
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MOUSE = 2'd1;
    localparam logic [1:0] ST_BTN   = 2'd2;

    // Counter holds HOLD_CYCLES-1 down to 0, so clog2 bits are always enough.
    localparam int unsigned   CW       = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic          primed;
    logic [11:0]   prev_m_x;
    logic [11:0]   prev_m_y;
    logic [11:0]   prev_b_x;
    logic [11:0]   prev_b_y;
    logic          m_act;
    logic          b_act;

    logic [11:0]   sel_x;
    logic [11:0]   sel_y;
    logic          sel_left;
    logic          enter_btn;

    // Positions at or above 12'hF00 are a decrement that wrapped below zero,
    // so they pin to the low edge rather than the high one.
    function automatic logic [11:0] clamp12(input logic [11:0] v,
                                            input logic [11:0] lo,
                                            input logic [11:0] hi);
        logic [11:0] r;
        if (v >= 12'hF00)  r = lo;
        else if (v < lo)   r = lo;
        else if (v > hi)   r = hi;
        else               r = v;
        return r;
    endfunction

    // Capture the previous sample of each source; the first cycle after reset only primes.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed   <= 1'b0;
            prev_m_x <= '0;
            prev_m_y <= '0;
            prev_b_x <= '0;
            prev_b_y <= '0;
        end else begin
            primed   <= 1'b1;
            prev_m_x <= m_xpos;
            prev_m_y <= m_ypos;
            prev_b_x <= b_xpos;
            prev_b_y <= b_ypos;
        end
    end

    // Activity: a position change or a held button on either source.
    always_comb begin
        m_act = primed & ((m_xpos != prev_m_x) | (m_ypos != prev_m_y) | m_left);
        b_act = primed & ((b_xpos != prev_b_x) | (b_ypos != prev_b_y) | b_left);
    end

    // Ownership arbitration and hold-counter next-state logic.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (m_act) begin
                    next_state = ST_MOUSE;
                    cnt_next   = CNT_LOAD;
                end else if (b_act) begin
                    next_state = ST_BTN;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_MOUSE: begin
                if (m_act) begin
                    cnt_next = CNT_LOAD;
                end else if (cnt == '0) begin
                    if (b_act) begin
                        next_state = ST_BTN;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_BTN: begin
                if (b_act) begin
                    cnt_next = CNT_LOAD;
                end else if (cnt == '0) begin
                    if (m_act) begin
                        next_state = ST_MOUSE;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Select the source that owns the cursor after this edge.
    always_comb begin
        sel_x     = m_xpos;
        sel_y     = m_ypos;
        sel_left  = m_left;
        if (next_state == ST_BTN) begin
            sel_x    = b_xpos;
            sel_y    = b_ypos;
            sel_left = b_left;
        end
        enter_btn = (next_state == ST_BTN) && (state != ST_BTN);
    end

    // State, hold counter and ownership flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            src_btn <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            src_btn <= (next_state == ST_BTN);
        end
    end

    // Registered cursor: owner's clamped position; click masked when idle or switching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos       <= X_MIN;
            ypos       <= Y_MIN;
            mouse_left <= 1'b0;
        end else begin
            if (next_state != ST_IDLE) begin
                xpos <= clamp12(sel_x, X_MIN, X_MAX);
                ypos <= clamp12(sel_y, Y_MIN, Y_MAX);
            end
            mouse_left <= (next_state != ST_IDLE) && (next_state == state) && sel_left;
        end
    end

    // Seed the button path with the pre-switch cursor on every hand-over to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_load <= 1'b0;
            seed_xpos <= '0;
            seed_ypos <= '0;
        end else begin
            seed_load <= enter_btn;
            if (enter_btn) begin
                seed_xpos <= xpos;
                seed_ypos <= ypos;
            end
        end
    end

endmodule

// File: tb/tb_pointer_src_arbiter.sv
// tb_pointer_src_arbiter
// Scenario tasks for the cursor arbiter plus a randomized run checked against a
// timestamp-based ownership model (owner + cycle of owner's last activity).

module tb_pointer_src_arbiter;

    localparam int HOLD = 4;
    localparam int XMIN = 0;
    localparam int XMAX = 1023;
    localparam int YMIN = 0;
    localparam int YMAX = 767;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] m_xpos, m_ypos, b_xpos, b_ypos;
    logic        m_left, b_left;
    logic [11:0] xpos, ypos, seed_xpos, seed_ypos;
    logic        mouse_left, src_btn, seed_load;

    int checks = 0;
    int errors = 0;

    pointer_src_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_xpos     (m_xpos),
        .m_ypos     (m_ypos),
        .m_left     (m_left),
        .b_xpos     (b_xpos),
        .b_ypos     (b_ypos),
        .b_left     (b_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .src_btn    (src_btn),
        .seed_load  (seed_load),
        .seed_xpos  (seed_xpos),
        .seed_ypos  (seed_ypos)
    );

    always #5 clk = ~clk;

    // Reference model: owner 0=none 1=mouse 2=button; ownership lapses once
    // HOLD cycles have passed since the owner's last activity.
    int          md_owner;
    longint      md_cyc;
    longint      md_last;
    bit          md_primed;
    logic [11:0] md_pmx, md_pmy, md_pbx, md_pby;
    logic [11:0] ex_x, ex_y, ex_sx, ex_sy;
    logic        ex_left, ex_src, ex_seed;

    function automatic logic [11:0] clampv(input logic [11:0] v, input int lo, input int hi);
        int iv;
        iv = int'(v);
        if (iv >= 3840) return 12'(lo);
        if (iv < lo)    return 12'(lo);
        if (iv > hi)    return 12'(hi);
        return v;
    endfunction

    task automatic model_reset();
        md_owner  = 0;
        md_cyc    = 0;
        md_last   = 0;
        md_primed = 1'b0;
        md_pmx = '0; md_pmy = '0; md_pbx = '0; md_pby = '0;
        ex_x = 12'(XMIN); ex_y = 12'(YMIN);
        ex_sx = '0; ex_sy = '0;
        ex_left = 1'b0; ex_src = 1'b0; ex_seed = 1'b0;
    endtask

    task automatic model_step();
        bit ma, ba;
        int nxt;
        ma  = md_primed && (m_xpos !== md_pmx || m_ypos !== md_pmy || m_left === 1'b1);
        ba  = md_primed && (b_xpos !== md_pbx || b_ypos !== md_pby || b_left === 1'b1);
        nxt = md_owner;
        if (md_owner == 0) begin
            if (ma)      nxt = 1;
            else if (ba) nxt = 2;
        end else if (md_owner == 1) begin
            if (ma) md_last = md_cyc;
            else if (md_cyc - md_last >= HOLD) nxt = ba ? 2 : 0;
        end else begin
            if (ba) md_last = md_cyc;
            else if (md_cyc - md_last >= HOLD) nxt = ma ? 1 : 0;
        end
        if (nxt != md_owner && nxt != 0) md_last = md_cyc;
        ex_seed = (nxt == 2 && md_owner != 2);
        if (ex_seed) begin
            ex_sx = ex_x;
            ex_sy = ex_y;
        end
        if (nxt == 1) begin
            ex_x    = clampv(m_xpos, XMIN, XMAX);
            ex_y    = clampv(m_ypos, YMIN, YMAX);
            ex_left = (nxt == md_owner) && m_left;
        end else if (nxt == 2) begin
            ex_x    = clampv(b_xpos, XMIN, XMAX);
            ex_y    = clampv(b_ypos, YMIN, YMAX);
            ex_left = (nxt == md_owner) && b_left;
        end else begin
            ex_left = 1'b0;
        end
        ex_src    = (nxt == 2);
        md_owner  = nxt;
        md_pmx = m_xpos; md_pmy = m_ypos; md_pbx = b_xpos; md_pby = b_ypos;
        md_primed = 1'b1;
        md_cyc++;
    endtask

    // One clock: model follows the edge, outputs are then sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        m_xpos = 12'd500; m_ypos = 12'd300; m_left = 1'b0;
        b_xpos = 12'd200; b_ypos = 12'd100; b_left = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #12;
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || mouse_left !== 1'b0 || src_btn !== 1'b0 ||
            seed_load !== 1'b0 || seed_xpos !== 12'd0 || seed_ypos !== 12'd0) begin
            errors++;
            $display("FAIL reset_values: x=%0d y=%0d left=%b src=%b seed=%b sx=%0d sy=%0d, want all zero",
                     xpos, ypos, mouse_left, src_btn, seed_load, seed_xpos, seed_ypos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (src_btn !== 1'b0 || xpos !== 12'd0 || ypos !== 12'd0 || mouse_left !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_no_grant cyc%0d: x=%0d y=%0d src=%b left=%b, want 0 0 0 0",
                         i, xpos, ypos, src_btn, mouse_left);
            end
        end
    endtask

    task automatic test_mouse_grant();
        m_xpos = 12'd501;
        tick();
        checks++;
        if (xpos !== 12'd501 || ypos !== 12'd300 || src_btn !== 1'b0 || md_owner != 1 || xpos !== ex_x) begin
            errors++;
            $display("FAIL mouse_grant: x=%0d y=%0d src=%b, want 501 300 0", xpos, ypos, src_btn);
        end
    endtask

    task automatic test_hold_ignore();
        b_ypos = 12'd101;
        tick();
        checks++;
        if (src_btn !== 1'b0 || seed_load !== 1'b0 || xpos !== 12'd501 || ypos !== 12'd300) begin
            errors++;
            $display("FAIL hold_ignores_btn: src=%b seed=%b x=%0d y=%0d, want 0 0 501 300",
                     src_btn, seed_load, xpos, ypos);
        end
        tick();
        tick();
        checks++;
        if (src_btn !== 1'b0 || xpos !== 12'd501) begin
            errors++;
            $display("FAIL hold_still_mouse: src=%b x=%0d, want 0 501", src_btn, xpos);
        end
    endtask

    task automatic test_handover_seed();
        b_xpos = 12'd201;
        tick();
        checks++;
        if (src_btn !== 1'b1 || seed_load !== 1'b1 || seed_xpos !== 12'd501 || seed_ypos !== 12'd300 ||
            xpos !== 12'd201 || ypos !== 12'd101 || mouse_left !== 1'b0) begin
            errors++;
            $display("FAIL handover: src=%b seed=%b sx=%0d sy=%0d x=%0d y=%0d left=%b, want 1 1 501 300 201 101 0",
                     src_btn, seed_load, seed_xpos, seed_ypos, xpos, ypos, mouse_left);
        end
        tick();
        checks++;
        if (seed_load !== 1'b0 || seed_xpos !== 12'd501 || seed_ypos !== 12'd300 || src_btn !== 1'b1) begin
            errors++;
            $display("FAIL seed_pulse_once: seed=%b sx=%0d sy=%0d src=%b, want 0 501 300 1",
                     seed_load, seed_xpos, seed_ypos, src_btn);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        tick();
        tick();
        checks++;
        if (src_btn !== 1'b0 || xpos !== 12'd201 || ypos !== 12'd101 || mouse_left !== 1'b0 || md_owner != 0) begin
            errors++;
            $display("FAIL btn_expiry_idle: src=%b x=%0d y=%0d left=%b, want 0 201 101 0",
                     src_btn, xpos, ypos, mouse_left);
        end
        m_xpos = 12'd600;
        b_xpos = 12'd250;
        tick();
        checks++;
        if (src_btn !== 1'b0 || seed_load !== 1'b0 || xpos !== 12'd600 || ypos !== 12'd300) begin
            errors++;
            $display("FAIL same_cycle_mouse_wins: src=%b seed=%b x=%0d y=%0d, want 0 0 600 300",
                     src_btn, seed_load, xpos, ypos);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < HOLD; i++) tick();
        b_xpos = 12'hFFF;
        tick();
        checks++;
        if (src_btn !== 1'b1 || xpos !== 12'd0 || seed_xpos !== 12'd600) begin
            errors++;
            $display("FAIL clamp_wrap_low: src=%b x=%0d sx=%0d, want 1 0 600", src_btn, xpos, seed_xpos);
        end
        b_xpos = 12'd1100;
        tick();
        checks++;
        if (xpos !== 12'd1023 || src_btn !== 1'b1) begin
            errors++;
            $display("FAIL clamp_x_high: x=%0d src=%b, want 1023 1", xpos, src_btn);
        end
        b_ypos = 12'd800;
        tick();
        checks++;
        if (ypos !== 12'd767 || xpos !== 12'd1023) begin
            errors++;
            $display("FAIL clamp_y_high: y=%0d x=%0d, want 767 1023", ypos, xpos);
        end
        b_xpos = 12'hF00;
        b_ypos = 12'hEFF;
        tick();
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd767) begin
            errors++;
            $display("FAIL clamp_edges: x=%0d y=%0d, want 0 767", xpos, ypos);
        end
        b_xpos = 12'd1023;
        b_ypos = 12'd767;
        tick();
        checks++;
        if (xpos !== 12'd1023 || ypos !== 12'd767) begin
            errors++;
            $display("FAIL clamp_at_max: x=%0d y=%0d, want 1023 767", xpos, ypos);
        end
    endtask

    task automatic test_reset_mid_grant();
        b_left = 1'b1;
        tick();
        checks++;
        if (mouse_left !== 1'b1 || src_btn !== 1'b1) begin
            errors++;
            $display("FAIL btn_click: left=%b src=%b, want 1 1", mouse_left, src_btn);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || mouse_left !== 1'b0 || src_btn !== 1'b0 ||
            seed_load !== 1'b0 || seed_xpos !== 12'd0 || seed_ypos !== 12'd0) begin
            errors++;
            $display("FAIL async_reset_abort: x=%0d y=%0d left=%b src=%b seed=%b sx=%0d sy=%0d, want all zero",
                     xpos, ypos, mouse_left, src_btn, seed_load, seed_xpos, seed_ypos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (src_btn !== 1'b0 || mouse_left !== 1'b0 || xpos !== 12'd0) begin
            errors++;
            $display("FAIL prime_no_activity: src=%b left=%b x=%0d, want 0 0 0", src_btn, mouse_left, xpos);
        end
        tick();
        checks++;
        if (src_btn !== 1'b1 || seed_load !== 1'b1 || seed_xpos !== 12'd0 || mouse_left !== 1'b0 ||
            xpos !== 12'd1023) begin
            errors++;
            $display("FAIL regrant_after_reset: src=%b seed=%b sx=%0d left=%b x=%0d, want 1 1 0 0 1023",
                     src_btn, seed_load, seed_xpos, mouse_left, xpos);
        end
        tick();
        checks++;
        if (mouse_left !== 1'b1 || seed_load !== 1'b0) begin
            errors++;
            $display("FAIL click_after_regrant: left=%b seed=%b, want 1 0", mouse_left, seed_load);
        end
        b_left = 1'b0;
    endtask

    function automatic logic [11:0] rand_coord();
        if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, 4095));
        return 12'($urandom_range(0, 1100));
    endfunction

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) m_xpos = rand_coord();
            if ($urandom_range(0, 11) == 0) m_ypos = rand_coord();
            m_left = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) b_xpos = rand_coord();
            if ($urandom_range(0, 11) == 0) b_ypos = rand_coord();
            b_left = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (xpos !== ex_x || ypos !== ex_y || mouse_left !== ex_left || src_btn !== ex_src ||
                seed_load !== ex_seed || seed_xpos !== ex_sx || seed_ypos !== ex_sy) begin
                errors++;
                $display("FAIL random cyc%0d: got x=%0d y=%0d l=%b s=%b sl=%b sx=%0d sy=%0d want x=%0d y=%0d l=%b s=%b sl=%b sx=%0d sy=%0d",
                         i, xpos, ypos, mouse_left, src_btn, seed_load, seed_xpos, seed_ypos,
                         ex_x, ex_y, ex_left, ex_src, ex_seed, ex_sx, ex_sy);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mouse_grant();
        test_hold_ignore();
        test_handover_seed();
        test_simultaneous();
        test_clamp();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
